// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared sizing for the rename register file
package reg_file_rename_pkg;

    localparam int RF_REG_NUM     = 32;
    localparam int RF_REG_WIDTH   = 5;
    localparam int RF_DATA_WIDTH  = 32;
    localparam int RF_ENTRY_WIDTH = 3;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - combinational source read with commit forwarding
module reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int REG_NUM     = RF_REG_NUM,
    parameter int REG_WIDTH   = RF_REG_WIDTH,
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int ENTRY_WIDTH = RF_ENTRY_WIDTH
) (
    input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]  data_arr,
    input  logic [REG_NUM-1:0]                  busy_arr,
    input  logic [REG_NUM-1:0][ENTRY_WIDTH-1:0] tag_arr,
    input  logic                                reg_modify,
    input  logic [REG_WIDTH-1:0]                reg_name,
    input  logic [DATA_WIDTH-1:0]               reg_data,
    input  logic [ENTRY_WIDTH-1:0]              reg_entry,
    input  logic                                read,
    input  logic [REG_WIDTH-1:0]                read_name,
    output logic [DATA_WIDTH-1:0]               read_data,
    output logic                                read_busy,
    output logic [ENTRY_WIDTH-1:0]              read_entry
);

    always_comb begin
        read_data  = '0;
        read_busy  = 1'b0;
        read_entry = '0;
        if (read && read_name != '0) begin
            read_data  = data_arr[read_name];
            read_busy  = busy_arr[read_name];
            read_entry = tag_arr[read_name];
            // The owning ROB entry retiring this cycle makes the value final now
            if (reg_modify && reg_name == read_name && busy_arr[read_name] &&
                tag_arr[read_name] == reg_entry) begin
                read_data = reg_data;
                read_busy = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with busy/tag rename status
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int REG_NUM     = RF_REG_NUM,
    parameter int REG_WIDTH   = RF_REG_WIDTH,
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int ENTRY_WIDTH = RF_ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_modify,
    input  logic [REG_WIDTH-1:0]   reg_name,
    input  logic [DATA_WIDTH-1:0]  reg_data,
    input  logic [ENTRY_WIDTH-1:0] reg_entry,
    input  logic                   lock_write,
    input  logic [REG_WIDTH-1:0]   lock_name,
    input  logic [ENTRY_WIDTH-1:0] lock_entry,
    input  logic                   flush,
    input  logic                   read1,
    input  logic [REG_WIDTH-1:0]   read_name1,
    output logic [DATA_WIDTH-1:0]  read_data1,
    output logic                   read_busy1,
    output logic [ENTRY_WIDTH-1:0] read_entry1,
    input  logic                   read2,
    input  logic [REG_WIDTH-1:0]   read_name2,
    output logic [DATA_WIDTH-1:0]  read_data2,
    output logic                   read_busy2,
    output logic [ENTRY_WIDTH-1:0] read_entry2,
    output logic [REG_WIDTH:0]     busy_count
);

    localparam int CW = REG_WIDTH + 1;

    logic [REG_NUM-1:0][DATA_WIDTH-1:0]  data_q, data_d;
    logic [REG_NUM-1:0]                  busy_q, busy_d;
    logic [REG_NUM-1:0][ENTRY_WIDTH-1:0] tag_q, tag_d;
    logic [CW-1:0]                       busy_count_q, busy_count_d;

    logic commit_en, commit_clear, lock_en, cnt_inc, cnt_dec;

    always_comb begin
        commit_en    = reg_modify && reg_name != '0;
        commit_clear = commit_en && busy_q[reg_name] && tag_q[reg_name] == reg_entry;
        lock_en      = lock_write && lock_name != '0 && !flush;
        cnt_inc      = lock_en && !busy_q[lock_name];
        // A same-register lock keeps the register busy, so the commit clear is void
        cnt_dec      = commit_clear && !(lock_en && lock_name == reg_name);

        data_d       = data_q;
        busy_d       = busy_q;
        tag_d        = tag_q;
        busy_count_d = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);

        if (commit_en) begin
            data_d[reg_name] = reg_data;
        end
        if (commit_clear) begin
            busy_d[reg_name] = 1'b0;
        end
        if (lock_en) begin
            busy_d[lock_name] = 1'b1;
            tag_d[lock_name]  = lock_entry;
        end
        if (flush) begin
            busy_d       = '0;
            busy_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            busy_q       <= '0;
            tag_q        <= '0;
            busy_count_q <= '0;
        end else begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    reg_read_port #(
        .REG_NUM(REG_NUM), .REG_WIDTH(REG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .ENTRY_WIDTH(ENTRY_WIDTH)
    ) u_read1 (
        .data_arr(data_q), .busy_arr(busy_q), .tag_arr(tag_q),
        .reg_modify(reg_modify), .reg_name(reg_name),
        .reg_data(reg_data), .reg_entry(reg_entry),
        .read(read1), .read_name(read_name1),
        .read_data(read_data1), .read_busy(read_busy1), .read_entry(read_entry1)
    );

    reg_read_port #(
        .REG_NUM(REG_NUM), .REG_WIDTH(REG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .ENTRY_WIDTH(ENTRY_WIDTH)
    ) u_read2 (
        .data_arr(data_q), .busy_arr(busy_q), .tag_arr(tag_q),
        .reg_modify(reg_modify), .reg_name(reg_name),
        .reg_data(reg_data), .reg_entry(reg_entry),
        .read(read2), .read_name(read_name2),
        .read_data(read_data2), .read_busy(read_busy2), .read_entry(read_entry2)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - randomized bench against a register-file reference model
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_modify;
    logic [4:0]  reg_name;
    logic [31:0] reg_data;
    logic [2:0]  reg_entry;
    logic        lock_write;
    logic [4:0]  lock_name;
    logic [2:0]  lock_entry;
    logic        flush;
    logic        read1, read2;
    logic [4:0]  read_name1, read_name2;
    logic [31:0] read_data1, read_data2;
    logic        read_busy1, read_busy2;
    logic [2:0]  read_entry1, read_entry2;
    logic [5:0]  busy_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [2:0]  m_tag  [32];

    reg_file_rename dut (
        .clk(clk), .rst(rst),
        .reg_modify(reg_modify), .reg_name(reg_name), .reg_data(reg_data), .reg_entry(reg_entry),
        .lock_write(lock_write), .lock_name(lock_name), .lock_entry(lock_entry),
        .flush(flush),
        .read1(read1), .read_name1(read_name1), .read_data1(read_data1),
        .read_busy1(read_busy1), .read_entry1(read_entry1),
        .read2(read2), .read_name2(read_name2), .read_data2(read_data2),
        .read_busy2(read_busy2), .read_entry2(read_entry2),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    // Expected source read: committed value unless pending, with the retiring owner forwarded
    function automatic void model_read(input logic rd, input logic [4:0] n,
                                       output logic [31:0] d, output logic b, output logic [2:0] e);
        d = 0; b = 0; e = 0;
        if (rd && n != 0) begin
            d = m_data[n]; b = m_busy[n]; e = m_tag[n];
            if (reg_modify && reg_name == n && m_busy[n] && m_tag[n] == reg_entry) begin
                d = reg_data; b = 0;
            end
        end
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else begin
            bit clear_it;
            clear_it = reg_modify && reg_name != 0 && m_busy[reg_name] && m_tag[reg_name] == reg_entry;
            if (reg_modify && reg_name != 0) m_data[reg_name] = reg_data;
            if (clear_it) m_busy[reg_name] = 0;
            if (lock_write && lock_name != 0 && !flush) begin
                m_busy[lock_name] = 1;
                m_tag[lock_name]  = lock_entry;
            end
            if (flush) foreach (m_busy[i]) m_busy[i] = 0;
        end
    endtask

    task automatic idle();
        rst = 0; reg_modify = 0; reg_name = 0; reg_data = 0; reg_entry = 0;
        lock_write = 0; lock_name = 0; lock_entry = 0; flush = 0;
        read1 = 0; read_name1 = 0; read2 = 0; read_name2 = 0;
    endtask

    // Check current outputs against the model, then clock the edge and advance the model
    task automatic do_cycle();
        logic [31:0] d;
        logic        b;
        logic [2:0]  e;
        #1;
        model_read(read1, read_name1, d, b, e);
        check("rd1_data", read_data1, d);
        check("rd1_busy", 32'(read_busy1), 32'(b));
        check("rd1_entry", 32'(read_entry1), 32'(e));
        model_read(read2, read_name2, d, b, e);
        check("rd2_data", read_data2, d);
        check("rd2_busy", 32'(read_busy2), 32'(b));
        check("rd2_entry", 32'(read_entry2), 32'(e));
        check("busy_count", 32'(busy_count), 32'(model_count()));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic lock(input logic [4:0] n, input logic [2:0] t);
        idle(); lock_write = 1; lock_name = n; lock_entry = t; do_cycle();
    endtask

    task automatic read_both(input logic [4:0] n);
        idle(); read1 = 1; read_name1 = n; read2 = 1; read_name2 = n;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        model_update();
        #1;

        read_both(5'd5);
        #1;
        check("reset_r5_data", read_data1, 32'h0);
        check("reset_r5_busy", 32'(read_busy1), 32'h0);
        check("reset_count", 32'(busy_count), 32'h0);
        do_cycle();

        lock(5'd5, 3'd3);
        read_both(5'd5);
        #1;
        check("lock_r5_busy", 32'(read_busy1), 32'h1);
        check("lock_r5_entry", 32'(read_entry1), 32'h3);
        check("lock_count", 32'(busy_count), 32'h1);
        do_cycle();

        read_both(5'd5);
        reg_modify = 1; reg_name = 5'd5; reg_data = 32'hDEADBEEF; reg_entry = 3'd3;
        #1;
        check("fwd_r5_data", read_data1, 32'hDEADBEEF);
        check("fwd_r5_busy", 32'(read_busy2), 32'h0);
        do_cycle();
        read_both(5'd5);
        do_cycle();

        lock(5'd7, 3'd2);
        lock(5'd7, 3'd6);
        idle(); reg_modify = 1; reg_name = 5'd7; reg_data = 32'h11; reg_entry = 3'd2; do_cycle();
        read_both(5'd7);
        #1;
        check("stale_r7_data", read_data1, 32'h11);
        check("stale_r7_busy", 32'(read_busy1), 32'h1);
        check("stale_r7_entry", 32'(read_entry1), 32'h6);
        check("stale_count", 32'(busy_count), 32'h1);
        do_cycle();

        lock(5'd9, 3'd1);
        idle();
        reg_modify = 1; reg_name = 5'd9; reg_data = 32'h22; reg_entry = 3'd1;
        lock_write = 1; lock_name = 5'd9; lock_entry = 3'd4;
        do_cycle();
        read_both(5'd9);
        #1;
        check("collide_r9_data", read_data1, 32'h22);
        check("collide_r9_busy", 32'(read_busy1), 32'h1);
        check("collide_r9_entry", 32'(read_entry1), 32'h4);
        do_cycle();

        lock(5'd1, 3'd1);
        lock(5'd2, 3'd2);
        lock(5'd3, 3'd3);
        idle(); flush = 1; lock_write = 1; lock_name = 5'd4; lock_entry = 3'd5; do_cycle();
        read_both(5'd4);
        #1;
        check("flush_r4_busy", 32'(read_busy1), 32'h0);
        check("flush_count", 32'(busy_count), 32'h0);
        do_cycle();

        idle();
        reg_modify = 1; reg_name = 5'd0; reg_data = 32'h5; reg_entry = 3'd0;
        lock_write = 1; lock_name = 5'd0; lock_entry = 3'd2;
        do_cycle();
        read_both(5'd0);
        #1;
        check("r0_data", read_data1, 32'h0);
        check("r0_busy", 32'(read_busy1), 32'h0);
        do_cycle();

        for (int i = 0; i < 600; i++) begin
            idle();
            rst        = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            reg_modify = $urandom_range(0, 1);
            reg_name   = 5'($urandom_range(0, 7));
            reg_data   = $urandom;
            reg_entry  = 3'($urandom_range(0, 7));
            lock_write = $urandom_range(0, 1);
            lock_name  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            lock_entry = 3'($urandom_range(0, 7));
            read1      = ($urandom_range(0, 7) != 0);
            read_name1 = ($urandom_range(0, 1) == 0) ? reg_name : 5'($urandom_range(0, 7));
            read2      = ($urandom_range(0, 7) != 0);
            read_name2 = 5'($urandom);
            if (i < 300 && ($urandom_range(0, 1) == 1) && m_busy[reg_name]) reg_entry = m_tag[reg_name];
            do_cycle();
        end

        for (int r = 0; r < 32; r++) begin
            read_both(5'(r));
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
